// File: rtl/axi_lite_pkg.sv
// Shared types for the two-port AXI-Lite arbiter: write/read FSM state encodings
// and the OKAY response code.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam int unsigned RESP_OKAY = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant index is registered whenever a grant is
// taken (en high and at least one request); the last-grant pointer moves only then.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       grant
);

  logic last;
  logic winner;

  // On contention the port that did not win last time goes first.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant <= 1'b0;
      last  <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      grant <= winner;
      last  <= winner;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-Lite master port between two slave ports, with independent
// round-robin write and read arbiters (one write and one read in flight at most).
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a valid, once raised, stays high with a stable
// payload until that edge, and ready may depend combinationally on valid.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  // slave port 0
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  // slave port 1
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [RESP_WIDTH-1:0]   s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  // shared master port
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready,
  // FSM state observation
  output wr_state_t               wr_state,
  output rd_state_t               rd_state
);

  localparam logic [RESP_WIDTH-1:0] OKAY = RESP_WIDTH'(RESP_OKAY);

  wr_state_t w_next;
  rd_state_t r_next;
  logic      wg, rg;
  logic      aw_done, w_done;
  logic      aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [ADDR_WIDTH-1:0]   sel_awaddr, sel_araddr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;
  logic                    sel_wvalid, sel_bready, sel_rready;

  rr_arb2 u_wr_arb (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .req   ({s1_axi_awvalid, s0_axi_awvalid}),
    .en    (wr_state == W_IDLE),
    .grant (wg)
  );

  rr_arb2 u_rd_arb (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .req   ({s1_axi_arvalid, s0_axi_arvalid}),
    .en    (rd_state == R_IDLE),
    .grant (rg)
  );

  assign sel_awaddr = wg ? s1_axi_awaddr : s0_axi_awaddr;
  assign sel_wdata  = wg ? s1_axi_wdata  : s0_axi_wdata;
  assign sel_wstrb  = wg ? s1_axi_wstrb  : s0_axi_wstrb;
  assign sel_wvalid = wg ? s1_axi_wvalid : s0_axi_wvalid;
  assign sel_bready = wg ? s1_axi_bready : s0_axi_bready;
  assign sel_araddr = rg ? s1_axi_araddr : s0_axi_araddr;
  assign sel_rready = rg ? s1_axi_rready : s0_axi_rready;

  // Handshakes at the master port, derived from state so no output feeds back.
  assign aw_hs = (wr_state == W_ADDR) && !aw_done && m0_axi_awready;
  assign w_hs  = (wr_state == W_ADDR) && !w_done && sel_wvalid && m0_axi_wready;
  assign b_hs  = (wr_state == W_RESP) && m0_axi_bvalid && sel_bready;
  assign ar_hs = (rd_state == R_ADDR) && m0_axi_arready;
  assign r_hs  = (rd_state == R_DATA) && m0_axi_rvalid && sel_rready;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= w_next;
      rd_state <= r_next;
      if (wr_state == W_ADDR) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Write path: next state and all write-direction outputs.
  always_comb begin
    w_next         = wr_state;
    m0_axi_awaddr  = '0;
    m0_axi_awvalid = 1'b0;
    m0_axi_wdata   = '0;
    m0_axi_wstrb   = '0;
    m0_axi_wvalid  = 1'b0;
    m0_axi_bready  = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    s0_axi_bresp   = OKAY;
    s1_axi_bresp   = OKAY;
    case (wr_state)
      W_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) w_next = W_ADDR;
      end
      W_ADDR: begin
        m0_axi_awaddr  = sel_awaddr;
        m0_axi_awvalid = !aw_done;
        m0_axi_wdata   = sel_wdata;
        m0_axi_wstrb   = sel_wstrb;
        m0_axi_wvalid  = !w_done && sel_wvalid;
        s0_axi_awready = !wg && !aw_done && m0_axi_awready;
        s1_axi_awready =  wg && !aw_done && m0_axi_awready;
        s0_axi_wready  = !wg && !w_done && m0_axi_wready;
        s1_axi_wready  =  wg && !w_done && m0_axi_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_RESP;
      end
      W_RESP: begin
        m0_axi_bready = sel_bready;
        if (wg) begin
          s1_axi_bvalid = m0_axi_bvalid;
          s1_axi_bresp  = m0_axi_bresp;
        end else begin
          s0_axi_bvalid = m0_axi_bvalid;
          s0_axi_bresp  = m0_axi_bresp;
        end
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read path: next state and all read-direction outputs.
  always_comb begin
    r_next         = rd_state;
    m0_axi_araddr  = '0;
    m0_axi_arvalid = 1'b0;
    m0_axi_rready  = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    s0_axi_rdata   = '0;
    s1_axi_rdata   = '0;
    s0_axi_rresp   = OKAY;
    s1_axi_rresp   = OKAY;
    case (rd_state)
      R_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) r_next = R_ADDR;
      end
      R_ADDR: begin
        m0_axi_araddr  = sel_araddr;
        m0_axi_arvalid = 1'b1;
        s0_axi_arready = !rg && m0_axi_arready;
        s1_axi_arready =  rg && m0_axi_arready;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: begin
        m0_axi_rready = sel_rready;
        if (rg) begin
          s1_axi_rvalid = m0_axi_rvalid;
          s1_axi_rdata  = m0_axi_rdata;
          s1_axi_rresp  = m0_axi_rresp;
        end else begin
          s0_axi_rvalid = m0_axi_rvalid;
          s0_axi_rdata  = m0_axi_rdata;
          s0_axi_rresp  = m0_axi_rresp;
        end
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule
